// File: rtl/hdmi_video_timing_ctrl.sv
// Raster timing sequencer for the HDMI/DVI transmit path: counters, sync/DE decode,
// blue-channel control pair and an 8-bar colour test pattern, all outputs registered.
module hdmi_video_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [1:0]  o_control,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_sof,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic [15:0] o_frame,
    output logic        o_busy
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BarW   = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;

    localparam logic [11:0] HLast   = 12'(HTotal - 1);
    localparam logic [11:0] VLast   = 12'(VTotal - 1);
    localparam logic [11:0] HAct    = 12'(H_ACTIVE);
    localparam logic [11:0] VAct    = 12'(V_ACTIVE);
    localparam logic [11:0] HsStart = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] VsStart = 12'(V_ACTIVE + V_FP);
    // Sync end bounds may reach 4096, so they are compared at 13 bits.
    localparam logic [12:0] HsEnd   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VsEnd   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BarW12  = 12'(BarW);
    localparam logic        SyncOn  = (SYNC_POL != 0);
    localparam logic        SyncOff = !SyncOn;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [15:0] frame_q, frame_d;
    logic        en_q;

    logic        hs_q, vs_q, de_q, sof_q, busy_q;
    logic [11:0] x_q, y_q;
    logic [23:0] rgb_q;

    logic        active, frame_end;
    logic        de_d, hs_d, vs_d, sof_d;
    logic [11:0] bar_idx;
    logic [2:0]  bar;
    logic [23:0] rgb_d;

    assign frame_end = (h_q == HLast) && (v_q == VLast);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        case (state_q)
            StIdle: begin
                h_d = '0;
                v_d = '0;
                if (en_q) state_d = StRun;
            end
            StRun, StDrain: begin
                if (h_q == HLast) begin
                    h_d = '0;
                    v_d = (v_q == VLast) ? 12'd0 : v_q + 12'd1;
                end else begin
                    h_d = h_q + 12'd1;
                end
                // A frame is never truncated: disable only takes effect at its end.
                if (frame_end) begin
                    frame_d = frame_q + 16'd1;
                    state_d = en_q ? StRun : StIdle;
                end else begin
                    state_d = en_q ? StRun : StDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active  = (state_q != StIdle);
        de_d    = active && (h_q < HAct) && (v_q < VAct);
        hs_d    = (active && (h_q >= HsStart) && ({1'b0, h_q} < HsEnd)) ? SyncOn : SyncOff;
        vs_d    = (active && (v_q >= VsStart) && ({1'b0, v_q} < VsEnd)) ? SyncOn : SyncOff;
        sof_d   = de_d && (h_q == 12'd0) && (v_q == 12'd0);
        bar_idx = h_q / BarW12;
        bar     = (bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0];
        // Bar colours white..black follow from inverted index bits.
        rgb_d   = de_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            en_q    <= 1'b0;
            hs_q    <= SyncOff;
            vs_q    <= SyncOff;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            en_q    <= i_enable;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
            busy_q  <= active;
            x_q     <= h_q;
            y_q     <= v_q;
            rgb_q   <= rgb_d;
        end
    end

    assign o_hs      = hs_q;
    assign o_vs      = vs_q;
    assign o_de      = de_q;
    assign o_control = {vs_q, hs_q};
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_sof     = sof_q;
    assign o_red     = rgb_q[23:16];
    assign o_green   = rgb_q[15:8];
    assign o_blue    = rgb_q[7:0];
    assign o_frame   = frame_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench: default-timing and small SYNC_POL=1 instances checked every cycle against a
// raster-position model, plus literal spot checks.
module tb_hdmi_video_timing_ctrl;

    localparam int NCYC    = 30000;
    localparam int RST_CYC = 15000;

    localparam int HA [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 2};
    localparam int HB [2] = '{48, 2};
    localparam int VA [2] = '{480, 4};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 1};
    localparam int VB [2] = '{33, 1};
    localparam bit POL [2] = '{1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en = 2'b11;

    logic [1:0]  hs_a, vs_a, de_a, sof_a, busy_a;
    logic [1:0]  ctrl_a [2];
    logic [11:0] x_a [2];
    logic [11:0] y_a [2];
    logic [7:0]  r_a [2];
    logic [7:0]  g_a [2];
    logic [7:0]  b_a [2];
    logic [15:0] frm_a [2];

    always #5 clk = ~clk;

    hdmi_video_timing_ctrl u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]),
        .o_hs(hs_a[0]), .o_vs(vs_a[0]), .o_de(de_a[0]), .o_control(ctrl_a[0]),
        .o_x(x_a[0]), .o_y(y_a[0]), .o_sof(sof_a[0]),
        .o_red(r_a[0]), .o_green(g_a[0]), .o_blue(b_a[0]),
        .o_frame(frm_a[0]), .o_busy(busy_a[0])
    );

    hdmi_video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]),
        .o_hs(hs_a[1]), .o_vs(vs_a[1]), .o_de(de_a[1]), .o_control(ctrl_a[1]),
        .o_x(x_a[1]), .o_y(y_a[1]), .o_sof(sof_a[1]),
        .o_red(r_a[1]), .o_green(g_a[1]), .o_blue(b_a[1]),
        .o_frame(frm_a[1]), .o_busy(busy_a[1])
    );

    int checks = 0;
    int failures = 0;

    // Model: 'gen' = generator producing frames, 'p' = linear raster position.
    bit          gen [2];
    int          p [2];
    bit          e [2];
    logic [15:0] frames [2];

    bit          x_de [2];
    bit          x_hs [2];
    bit          x_vs [2];
    bit          x_sof [2];
    bit          x_busy [2];
    int          x_x [2];
    int          x_y [2];
    logic [23:0] x_rgb [2];
    logic [15:0] x_frm [2];

    function automatic logic [23:0] bar_rgb(input int bar);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return tbl[bar];
    endfunction

    task automatic set_idle(input int i);
        x_de[i]   = 1'b0;
        x_hs[i]   = !POL[i];
        x_vs[i]   = !POL[i];
        x_sof[i]  = 1'b0;
        x_busy[i] = 1'b0;
        x_x[i]    = 0;
        x_y[i]    = 0;
        x_rgb[i]  = 24'h0;
        x_frm[i]  = frames[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            gen[i] = 1'b0;
            p[i] = 0;
            e[i] = 1'b0;
            frames[i] = 16'h0;
            set_idle(i);
        end
    endtask

    task automatic model_step(input int i, input bit en_now);
        int ht, tot, h, v, bar;
        ht  = HA[i] + HF[i] + HS[i] + HB[i];
        tot = ht * (VA[i] + VF[i] + VS[i] + VB[i]);
        if (gen[i]) begin
            h = p[i] % ht;
            v = p[i] / ht;
            x_de[i]   = (h < HA[i]) && (v < VA[i]);
            x_hs[i]   = ((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i])) ? POL[i] : !POL[i];
            x_vs[i]   = ((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i])) ? POL[i] : !POL[i];
            x_sof[i]  = x_de[i] && (p[i] == 0);
            x_busy[i] = 1'b1;
            x_x[i]    = h;
            x_y[i]    = v;
            bar = h / (HA[i] / 8);
            if (bar > 7) bar = 7;
            x_rgb[i]  = x_de[i] ? bar_rgb(bar) : 24'h0;
        end else begin
            set_idle(i);
        end
        // Enable takes one register stage before the sequencer sees it.
        if (!gen[i]) begin
            if (e[i]) begin
                gen[i] = 1'b1;
                p[i] = 0;
            end
        end else begin
            p[i]++;
            if (p[i] == tot) begin
                p[i] = 0;
                frames[i] = frames[i] + 16'd1;
                if (!e[i]) gen[i] = 1'b0;
            end
        end
        x_frm[i] = frames[i];
        e[i] = en_now;
    endtask

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", name, i, $time, act, want);
        end
    endtask

    task automatic compare(input int i);
        chk("de", i, de_a[i], x_de[i]);
        chk("hs", i, hs_a[i], x_hs[i]);
        chk("vs", i, vs_a[i], x_vs[i]);
        chk("control", i, ctrl_a[i], {x_vs[i], x_hs[i]});
        chk("sof", i, sof_a[i], x_sof[i]);
        chk("busy", i, busy_a[i], x_busy[i]);
        chk("x", i, x_a[i], x_x[i]);
        chk("y", i, y_a[i], x_y[i]);
        chk("rgb", i, {r_a[i], g_a[i], b_a[i]}, x_rgb[i]);
        chk("frame", i, frm_a[i], x_frm[i]);
    endtask

    task automatic check_reset_literals();
        chk("rst_hs", 0, hs_a[0], 1);
        chk("rst_hs", 1, hs_a[1], 0);
        chk("rst_ctrl", 0, ctrl_a[0], 2'b11);
        chk("rst_ctrl", 1, ctrl_a[1], 2'b00);
        for (int i = 0; i < 2; i++) begin
            chk("rst_de", i, de_a[i], 0);
            chk("rst_xy", i, {x_a[i], y_a[i]}, 0);
            chk("rst_rgb", i, {r_a[i], g_a[i], b_a[i]}, 0);
            chk("rst_frame", i, frm_a[i], 0);
            chk("rst_busy", i, busy_a[i], 0);
            chk("rst_sof", i, sof_a[i], 0);
        end
    endtask

    task automatic spot_checks(input int cyc);
        if (cyc == 2) begin
            chk("lat_sof_early", 0, sof_a[0], 0);
            chk("lat_busy_early", 1, busy_a[1], 0);
        end
        if (cyc == 3) begin
            chk("lat_sof", 0, sof_a[0], 1);
            chk("lat_sof", 1, sof_a[1], 1);
            chk("lat_de", 0, de_a[0], 1);
        end
        if (cyc == 250) chk("frame_count", 1, frm_a[1], 2);
        if (busy_a[0] && y_a[0] == 12'd0) begin
            case (x_a[0])
                12'd79:  chk("bar0_edge", 0, {r_a[0], g_a[0], b_a[0]}, 24'hFFFFFF);
                12'd80:  chk("bar1_start", 0, {r_a[0], g_a[0], b_a[0]}, 24'hFFFF00);
                12'd600: chk("bar7", 0, {de_a[0], r_a[0], g_a[0], b_a[0]}, 25'h1000000);
                12'd640: chk("blank_x640", 0, {de_a[0], r_a[0], g_a[0], b_a[0]}, 0);
                12'd655: chk("hs_before", 0, hs_a[0], 1);
                12'd656: chk("hs_start", 0, hs_a[0], 0);
                12'd751: chk("hs_last", 0, hs_a[0], 0);
                12'd752: chk("hs_after", 0, hs_a[0], 1);
                default: ;
            endcase
        end
        if (busy_a[1]) begin
            if (x_a[1] == 12'd9)  chk("s_hs_before", 1, hs_a[1], 0);
            if (x_a[1] == 12'd10) chk("s_hs_on", 1, hs_a[1], 1);
            if (y_a[1] == 12'd4)  chk("s_vs_before", 1, vs_a[1], 0);
            if (y_a[1] == 12'd5)  chk("s_vs_on", 1, vs_a[1], 1);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_literals();
        compare(0);
        compare(1);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clk);
            model_step(0, en[0]);
            model_step(1, en[1]);
            if (cyc == RST_CYC) begin
                // Asynchronous reset between edges must clear outputs immediately.
                #2 rst_n = 1'b0;
                #1 check_reset_literals();
                model_reset();
            end
            @(negedge clk);
            compare(0);
            compare(1);
            spot_checks(cyc);
            if (cyc == RST_CYC) rst_n = 1'b1;
            en[0] = 1'b1;
            if (cyc >= 300 && $urandom_range(39) == 0) en[1] = ~en[1];
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdmi_video_timing_ctrl.md
Name: hdmi_video_timing_ctrl

Overview:
- Raster timing sequencer that drives the three TMDS channel encoders of the HDMI/DVI transmit path.
- Generates horizontal/vertical counters, the active-video window, hsync/vsync with programmable polarity, and the blue-channel control pair {vs,hs}.
- Includes an 8-bar colour test-pattern source so the link can be brought up without a framebuffer.
- All outputs are registered and mutually aligned. Encoders consume them directly in the pixel-clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of o_hs/o_vs (0 = active-low)

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  start/keep generating frames
- o_hs  out  1  horizontal sync, polarity per SYNC_POL
- o_vs  out  1  vertical sync, polarity per SYNC_POL
- o_de  out  1  1 = active video (encoder selects pixel data)
- o_control  out  2  {o_vs,o_hs} for the blue encoder; 2'b00 for red/green handled by top level
- o_x  out  12  horizontal position of current output cycle
- o_y  out  12  vertical position of current output cycle
- o_sof  out  1  one-cycle pulse on the first active pixel (0,0)
- o_red, o_green, o_blue  out  8 each  test-pattern pixel, 0 when o_de=0
- o_frame  out  16  completed-frame counter, wraps at 2^16
- o_busy  out  1  1 while in RUN or DRAIN

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800x525.
- Reset (async assert, sync deassert assumed at top level) sets all outputs and counters as follows:
  - Counters h=0, v=0; state IDLE.
  - o_hs = o_vs = ~SYNC_POL; o_de = 0; o_control = {~SYNC_POL,~SYNC_POL}.
  - o_x = o_y = 0; o_sof = 0; colours = 0; o_frame = 0; o_busy = 0.
- State machine:
  - IDLE: counters held at 0, outputs at reset values. i_enable=1 → RUN; the next clock presents (0,0).
  - RUN: h increments each clock. At h=H_TOTAL-1, h→0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, v→0 and o_frame increments. If i_enable=0 at any cycle → DRAIN (frame not truncated).
  - DRAIN: continue counting. At end of frame (h=H_TOTAL-1, v=V_TOTAL-1), o_frame increments. Then go to IDLE, or back to RUN if i_enable=1 on that cycle. If i_enable reasserts earlier in DRAIN → RUN.
- Decode, evaluated on counter state (h,v) and registered, so every output in a cycle describes the same (o_x,o_y):
  - o_de = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hs asserted when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for whole lines (changes at h=0).
  - o_sof = o_de && h==0 && v==0.
- Latency: i_enable high at edge N (in IDLE) → outputs show (0,0), o_de=1, o_sof=1 at edge N+2.
- Pattern: bar = h / (H_ACTIVE/8), clamped to 7. Colours for bars 0..7: white FF/FF/FF, yellow FF/FF/00, cyan 00/FF/FF, green 00/FF/00, magenta FF/00/FF, red FF/00/00, blue 00/00/FF, black 00/00/00. Forced to 0 outside o_de.
- Widths: counters 12 bits; parameters must satisfy H_TOTAL, V_TOTAL ≤ 4096. Divide is by a constant (elaborated).
- Reset mid-frame: immediate return to reset values; no partial o_frame increment.

Test Plan:
- Reset then i_enable=1 with defaults → o_sof exactly once per 420000 clocks; o_frame=1 after first frame end; o_de high for 640 consecutive clocks per line, 480 lines.
- Sync check, defaults → o_hs low for exactly 96 clocks starting at o_x=656. o_vs low on lines 490–491, toggling at o_x=0. o_control={o_vs,o_hs} every cycle.
- SYNC_POL=1, small timing (H 8/2/2/2, V 4/1/1/1) → syncs high-asserted; H_TOTAL=14, V_TOTAL=7 period verified.
- Pattern, defaults → o_x=0..79 gives FF/FF/FF; 80 gives FF/FF/00; 560..639 gives 00/00/00; o_x=640 gives 00/00/00 with o_de=0.
- Drop i_enable at (100,200) → frame completes, o_frame increments, o_busy falls, outputs idle. Reassert during DRAIN → continuous frames with no gap.
- Assert i_rst_n=0 mid-line asynchronously (between clock edges) → all outputs at reset values before the next edge; o_frame=0.
